aes_text_stream_adapter: RTL
============================

// Module: aes_text_stream_adapter
// PURPOSE
//  Word-stream front/back end for aes_cipher_top. Packs four 32-bit input words into the
//  128-bit text_in bus and issues a single-cycle ld strobe to the core. Captures
//  text_out when the core pulses done. Returns the result as four 32-bit words over a
//  valid/ready stream.
// PARAMETERS
//  WORD_W       32   stream word width; fixed at 32 (BLK_W/WORD_W = 4 words per block)
//  BLK_W        128  AES block width
//  TIMEOUT_CYC  64   max cycles in BUSY waiting for aes_done before flagging an error
// PORTS
//  clk           in   1    single clock, rising edge
//  rst           in   1    synchronous reset, active-low
//  s_valid       in   1    input word valid
//  s_ready       out  1    input word accepted when s_valid&s_ready
//  s_data        in   32   input plaintext word
//  aes_ld        out  1    one-cycle load strobe to aes_cipher_top.ld
//  aes_text_in   out  128  block to aes_cipher_top.text_in
//  aes_done      in   1    aes_cipher_top.done
//  aes_text_out  in   128  aes_cipher_top.text_out
//  m_valid       out  1    output word valid
//  m_ready       in   1    downstream accept
//  m_data        out  32   output ciphertext word
//  busy          out  1    high in any state other than FILL
//  timeout_err   out  1    sticky; set on BUSY timeout, cleared only by reset
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state=FILL, word idx=0, aes_ld=0, aes_text_in=0, out buffer=0,
//   m_valid=0, s_ready=1 (on the first cycle after reset), busy=0, timeout_err=0, timeout counter=0.
//   Reset mid-operation aborts any partial block or drain with no further ld or m_valid.
//  Word order: first accepted word -> aes_text_in[127:96], 4th -> [31:0]. Output uses the same
//   order: first m_data = text_out[127:96].
//  FSM FILL -> LOAD -> BUSY -> DRAIN -> FILL:
//   FILL: s_ready=1. Each handshake writes the addressed slice and increments idx (2-bit, wraps).
//    The 4th handshake at cycle T moves the FSM to LOAD.
//   LOAD: aes_ld=1 for exactly cycle T+1; s_ready=0; next state BUSY; timeout counter cleared.
//   BUSY: waits for aes_done. On aes_done, registers aes_text_out into the out buffer and moves to
//    DRAIN; m_valid rises the following cycle. The counter increments each BUSY cycle. If it
//    reaches TIMEOUT_CYC without done: set timeout_err, go to FILL, discard the block.
//   DRAIN: m_valid=1; m_data is stable while m_valid&!m_ready. Each handshake advances idx.
//    The 4th handshake returns the FSM to FILL, with m_valid=0 the next cycle.
//  aes_text_in is registered and holds its value from the 4th input handshake until the next
//   block's first word is written; it never changes during LOAD or BUSY.
//  aes_done seen outside BUSY (FILL, LOAD, DRAIN) is ignored and does not disturb the out buffer.
//  s_valid is ignored outside FILL (no acceptance, no data change). Dropping s_valid mid-block
//   stalls the FSM in FILL with no timeout.
//  The block has no internal throughput overlap: the next block is accepted only after the
//   drain completes.
//  busy is a combinational decode of state != FILL.
// TESTING
//  1 FIPS-197 vector: words 00112233,44556677,8899aabb,ccddeeff -> aes_text_in=
//    00112233445566778899aabbccddeeff; aes_ld high exactly one cycle (T+1); model done with
//    text_out 69c4e0d86a7b0430d8cdb78070b4c55a -> m_data 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
//  2 Backpressure: hold m_ready=0 for 5 cycles mid-drain -> m_valid and m_data stable; no word
//    lost or repeated; s_ready=0 throughout.
//  3 Input gaps: s_valid toggling 1,0,1,0... -> exactly 4 writes, correct packing, a single
//    aes_ld pulse.
//  4 Timeout: withhold aes_done -> after 64 BUSY cycles timeout_err=1 and the FSM is in FILL
//    (s_ready=1); a following good block completes normally with timeout_err still 1.
//  5 Spurious done: pulse aes_done in FILL and in DRAIN -> out buffer and m_data unchanged.
//  6 Reset after the 2nd word, and again during DRAIN -> all outputs at reset values next cycle;
//    the next 4-word block packs starting at [127:96].

Source files
------------

// File: rtl/aes_text_stream_adapter.sv
// aes_text_stream_adapter: packs four 32-bit stream words into an AES block, loads the core,
// captures the result and streams it back out as four words.
module aes_text_stream_adapter #(
  parameter int WORD_W      = 32,
  parameter int BLK_W       = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              aes_ld,
  output logic [BLK_W-1:0]  aes_text_in,
  input  logic              aes_done,
  input  logic [BLK_W-1:0]  aes_text_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              busy,
  output logic              timeout_err
);
  localparam logic [1:0] FILL = 2'd0, LOAD = 2'd1, BUSY = 2'd2, DRAIN = 2'd3;
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [1:0] state, idx;
  logic [CW-1:0] cnt;
  logic [BLK_W-1:0] obuf;
  assign s_ready = state == FILL;
  assign aes_ld  = state == LOAD;
  assign m_valid = state == DRAIN;
  assign busy    = state != FILL;
  // one word index serves both directions; it is back at 0 whenever a block boundary is reached
  assign m_data  = obuf[BLK_W-1-WORD_W*idx -: WORD_W];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FILL;
      idx         <= '0;
      cnt         <= '0;
      aes_text_in <= '0;
      obuf        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        FILL: if (s_valid) begin
          aes_text_in[BLK_W-1-WORD_W*idx -: WORD_W] <= s_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: if (aes_done) begin
          obuf  <= aes_text_out;
          state <= DRAIN;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          timeout_err <= 1'b1;
          state       <= FILL;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: if (m_ready) begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= FILL;
        end
      endcase
    end
  end
endmodule
